// File: rtl/conv1_feeder.sv
// conv1_feeder: loads the four kernel biases once per run, then streams overlapping
// sample windows plus matching packed weight words to conv layer 1, one window per conv_end.
module conv1_feeder #(
  parameter int KERNEL_SIZE = 32,
  parameter int STRIDE      = 8,
  parameter int SIG_LEN     = 512,
  parameter int N_WIN       = 61,
  parameter int N_CH        = 42,
  parameter int DATA_W      = 8,
  parameter int WEIGHT_W    = 8,
  parameter int BIAS_W      = 8,
  parameter int ADDR_W      = 15,
  parameter int GAP         = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  conv_end,
  output logic [ADDR_W-1:0]     smp_addr,
  output logic                  smp_rd,
  input  logic [DATA_W-1:0]     smp_q,
  output logic [4:0]            w_addr,
  input  logic [4*WEIGHT_W-1:0] w_q,
  output logic [1:0]            b_addr,
  input  logic [BIAS_W-1:0]     b_q,
  output logic [DATA_W-1:0]     data_in,
  output logic                  valid,
  output logic [4*WEIGHT_W-1:0] c1_w,
  output logic                  c1_w_en,
  output logic [BIAS_W-1:0]     c1_b,
  output logic                  c1_b_en,
  output logic                  busy,
  output logic                  done,
  output logic [5:0]            win_idx,
  output logic [5:0]            ch_idx
);

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0]  LAST_TAP  = CNT_W'(KERNEL_SIZE - 1);
  localparam logic [CNT_W-1:0]  LAST_BIAS = CNT_W'(3);
  localparam logic [CNT_W-1:0]  LAST_GAP  = CNT_W'(GAP - 1);
  localparam logic [5:0]        LAST_WIN  = 6'(N_WIN - 1);
  localparam logic [5:0]        LAST_CH   = 6'(N_CH - 1);
  localparam logic [ADDR_W-1:0] STRIDE_A  = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] SIG_LEN_A = ADDR_W'(SIG_LEN);

  typedef enum logic [2:0] {IDLE, BIAS, STREAM, WAIT_END, GAP_S, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        win_q, win_d;
  logic [5:0]        ch_q, ch_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] ch_base_q, ch_base_d;
  logic              valid_q, valid_d;
  logic              b_en_q, b_en_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      win_q     <= '0;
      ch_q      <= '0;
      base_q    <= '0;
      ch_base_q <= '0;
      valid_q   <= 1'b0;
      b_en_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      ch_q      <= ch_d;
      base_q    <= base_d;
      ch_base_q <= ch_base_d;
      valid_q   <= valid_d;
      b_en_q    <= b_en_d;
    end
  end

  // cnt_q is shared: bias index in BIAS, tap index in STREAM, idle count in GAP_S
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    ch_d      = ch_q;
    base_d    = base_q;
    ch_base_d = ch_base_q;
    valid_d   = (state_q == STREAM);
    b_en_d    = (state_q == BIAS);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = BIAS;
          cnt_d     = '0;
          win_d     = '0;
          ch_d      = '0;
          base_d    = '0;
          ch_base_d = '0;
        end
      end
      BIAS: begin
        if (cnt_q == LAST_BIAS) begin
          state_d = STREAM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STREAM: begin
        if (cnt_q == LAST_TAP) begin
          state_d = WAIT_END;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_END: begin
        if (conv_end) begin
          if (win_q < LAST_WIN) begin
            win_d   = win_q + 6'd1;
            base_d  = base_q + STRIDE_A;
            state_d = GAP_S;
          end else if (ch_q < LAST_CH) begin
            win_d     = '0;
            ch_d      = ch_q + 6'd1;
            ch_base_d = ch_base_q + SIG_LEN_A;
            base_d    = ch_base_q + SIG_LEN_A;
            state_d   = GAP_S;
          end else begin
            state_d = DONE;
          end
        end
      end
      GAP_S: begin
        if (cnt_q == LAST_GAP) begin
          state_d = STREAM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory read data is already registered, so it is forwarded under the delayed qualifier
  always_comb begin
    smp_rd   = (state_q == STREAM);
    smp_addr = smp_rd ? (base_q + ADDR_W'(cnt_q)) : '0;
    w_addr   = smp_rd ? cnt_q : '0;
    b_addr   = (state_q == BIAS) ? cnt_q[1:0] : '0;
    valid    = valid_q;
    c1_w_en  = valid_q;
    data_in  = valid_q ? smp_q : '0;
    c1_w     = valid_q ? w_q : '0;
    c1_b_en  = b_en_q;
    c1_b     = b_en_q ? b_q : '0;
    busy     = (state_q == BIAS) || (state_q == STREAM) ||
               (state_q == WAIT_END) || (state_q == GAP_S);
    done     = (state_q == DONE);
    win_idx  = win_q;
    ch_idx   = ch_q;
  end

endmodule
